// File: rtl/button_conditioner_if.sv
// Button bus between the raw board buttons and the conditioned outputs.
interface button_conditioner_if #(
  parameter int unsigned N_BTN = 4
);

  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_level;
  logic [N_BTN-1:0] o_press_pulse;
  logic [N_BTN-1:0] o_release_pulse;
  logic [N_BTN-1:0] o_hold_pulse;
  logic [N_BTN-1:0] o_held;

  // Board / stimulus side: drives the raw buttons, observes conditioned outputs.
  modport master (
    output i_btn,
    input  o_level,
    input  o_press_pulse,
    input  o_release_pulse,
    input  o_hold_pulse,
    input  o_held
  );

  // Conditioner side.
  modport slave (
    input  i_btn,
    output o_level,
    output o_press_pulse,
    output o_release_pulse,
    output o_hold_pulse,
    output o_held
  );

endinterface

// File: rtl/button_conditioner.sv
// Per-channel button front end: 2-FF synchroniser, debounce, press/release
// pulses and long-press (hold) detection. All outputs are registered.
module button_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned HOLD_CYCLES     = 100_000_000
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  button_conditioner_if.slave if_btn
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [DB_W-1:0]  r_db_cnt   [N_BTN];
  logic [HD_W-1:0]  r_hold_cnt [N_BTN];
  logic [N_BTN-1:0] r_level;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_release;
  logic [N_BTN-1:0] r_hold_pulse;
  logic [N_BTN-1:0] r_held;

  logic [DB_W-1:0]  w_db_cnt   [N_BTN];
  logic [HD_W-1:0]  w_hold_cnt [N_BTN];
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  logic [N_BTN-1:0] w_hold_pulse;
  logic [N_BTN-1:0] w_held;

  // Plain two-flop synchroniser chain, no logic between the stages.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= if_btn.i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state for debounce and hold tracking of every channel.
  always_comb begin
    w_db_cnt     = r_db_cnt;
    w_hold_cnt   = r_hold_cnt;
    w_level      = r_level;
    w_held       = r_held;
    w_press      = '0;
    w_release    = '0;
    w_hold_pulse = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      // Debounce: any sample equal to the current level restarts the count.
      if (r_sync2[i] == r_level[i]) begin
        w_db_cnt[i] = '0;
      end else if (r_db_cnt[i] == DB_LAST) begin
        w_db_cnt[i]  = '0;
        w_level[i]   = r_sync2[i];
        w_press[i]   = r_sync2[i];
        w_release[i] = ~r_sync2[i];
      end else begin
        w_db_cnt[i] = r_db_cnt[i] + DB_W'(1);
      end

      // Hold: count while high and not yet held; release wins over a
      // coincident hold so o_held can never outlive o_level.
      if (!r_level[i]) begin
        w_hold_cnt[i] = '0;
      end else if (!w_level[i]) begin
        w_held[i] = 1'b0;
      end else if (!r_held[i]) begin
        if (r_hold_cnt[i] == HD_LAST) begin
          w_hold_pulse[i] = 1'b1;
          w_held[i]       = 1'b1;
        end else begin
          w_hold_cnt[i] = r_hold_cnt[i] + HD_W'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_db_cnt     <= '{default: '0};
      r_hold_cnt   <= '{default: '0};
      r_level      <= '0;
      r_press      <= '0;
      r_release    <= '0;
      r_hold_pulse <= '0;
      r_held       <= '0;
    end else begin
      r_db_cnt     <= w_db_cnt;
      r_hold_cnt   <= w_hold_cnt;
      r_level      <= w_level;
      r_press      <= w_press;
      r_release    <= w_release;
      r_hold_pulse <= w_hold_pulse;
      r_held       <= w_held;
    end
  end

  assign if_btn.o_level         = r_level;
  assign if_btn.o_press_pulse   = r_press;
  assign if_btn.o_release_pulse = r_release;
  assign if_btn.o_hold_pulse    = r_hold_pulse;
  assign if_btn.o_held          = r_held;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE=4, HOLD=16, 4 channels).
module tb_button_conditioner;

  localparam int unsigned NB = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned HD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] b;

  always #5 clk = ~clk;

  button_conditioner_if #(.N_BTN(NB)) bif ();

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HD)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .if_btn(bif)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sync = input sampled two edges earlier; a new level is
  // accepted after DB consecutive edges of disagreement; a hold fires when the
  // level has been high for HD edges since it rose.
  bit m_s1 [NB];
  bit m_s2 [NB];
  bit m_lvl [NB];
  bit m_held [NB];
  int m_run [NB];
  int m_since [NB];
  logic [NB-1:0] e_level, e_press, e_rel, e_hold, e_held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NB; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_held[c] = 0;
        m_run[c] = 0; m_since[c] = 0;
      end
      e_level = '0; e_press = '0; e_rel = '0; e_hold = '0; e_held = '0;
    end else begin
      e_press = '0; e_rel = '0; e_hold = '0;
      for (int c = 0; c < NB; c++) begin
        bit sync;
        bit prev;
        sync = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = bif.i_btn[c];
        prev = m_lvl[c];
        if (sync != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == int'(DB)) begin
            m_lvl[c] = sync;
            m_run[c] = 0;
            if (sync) e_press[c] = 1'b1;
            else      e_rel[c]   = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
        if (prev && !m_lvl[c]) m_held[c] = 0;
        if (!prev && m_lvl[c]) m_since[c] = 0;
        else if (m_lvl[c])     m_since[c]++;
        if (prev && m_lvl[c] && !m_held[c] && m_since[c] == int'(HD)) begin
          e_hold[c] = 1'b1;
          m_held[c] = 1;
        end
        e_level[c] = m_lvl[c];
        e_held[c]  = m_held[c];
      end
    end
  end

  // Continuous scoreboard, sampled well after the active edge.
  always @(posedge clk) begin
    #2;
    chk("scoreboard",
        32'({bif.o_held, bif.o_hold_pulse, bif.o_release_pulse, bif.o_press_pulse, bif.o_level}),
        32'({e_held, e_hold, e_rel, e_press, e_level}));
  end

  // Drive inputs on the falling edge, return just after the next rising edge.
  task automatic step(input logic [3:0] v);
    @(negedge clk);
    bif.i_btn = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] outs();
    return {bif.o_held, bif.o_hold_pulse, bif.o_release_pulse, bif.o_press_pulse, bif.o_level};
  endfunction

  typedef struct {
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] hp;
    logic [3:0] hld;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int npress, nrel, nhold, nheld, first_n, rise_e;
    bit found, prev_held;
    int bpat [8];

    rst_n = 1'b0;
    b = '0;
    bif.i_btn = '0;

    // Clean press then release of ch0: sampled at entry 0, accepted at entry 5;
    // released at entry 8, accepted at entry 13.
    for (int j = 0; j < 15; j++) begin
      tbl[j].btn = (j < 8) ? 4'b0001 : 4'b0000;
      tbl[j].lvl = (j >= 5 && j <= 12) ? 4'b0001 : 4'b0000;
      tbl[j].prs = (j == 5) ? 4'b0001 : 4'b0000;
      tbl[j].rel = (j == 13) ? 4'b0001 : 4'b0000;
      tbl[j].hp  = 4'b0000;
      tbl[j].hld = 4'b0000;
    end
    bpat = '{1, 1, 1, 0, 1, 1, 1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_cycle_after_reset", 32'(outs()), 32'd0);
    repeat (2) step(b);

    for (int j = 0; j < 15; j++) begin
      step(tbl[j].btn);
      chk($sformatf("tbl%0d_level", j),   32'(bif.o_level),         32'(tbl[j].lvl));
      chk($sformatf("tbl%0d_press", j),   32'(bif.o_press_pulse),   32'(tbl[j].prs));
      chk($sformatf("tbl%0d_release", j), 32'(bif.o_release_pulse), 32'(tbl[j].rel));
      chk($sformatf("tbl%0d_hold", j),    32'({bif.o_hold_pulse, bif.o_held}), 32'({tbl[j].hp, tbl[j].hld}));
    end
    b = '0;

    // Bounce on ch1: last rising sample at index 4, acceptance at index 9.
    npress = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) b[1] = bpat[i][0];
      else       b[1] = 1'b1;
      step(b);
      chk($sformatf("bounce_level_i%0d", i), 32'(bif.o_level[1]), (i >= 9) ? 32'd1 : 32'd0);
      npress += int'(bif.o_press_pulse[1]);
    end
    chk("bounce_press_count", 32'(npress), 32'd1);

    // Simultaneous: press ch0 and release ch1 on the same cycle.
    b[0] = 1'b1;
    b[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(b);
      chk($sformatf("simul_i%0d", i),
          32'({bif.o_press_pulse[1], bif.o_release_pulse[0], bif.o_press_pulse[0], bif.o_release_pulse[1]}),
          (i == 5) ? 32'h3 : 32'h0);
    end
    b[0] = 1'b0;
    repeat (8) step(b);

    // Long press on ch2.
    b[2] = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(b);
      if (bif.o_level[2]) found = 1;
    end
    chk("long_rise_seen", 32'(found), 32'd1);
    nhold = 0;
    first_n = 0;
    for (int n = 1; n <= 30; n++) begin
      step(b);
      if (bif.o_hold_pulse[2]) begin
        nhold++;
        if (first_n == 0) first_n = n;
      end
    end
    chk("long_hold_delay", 32'(first_n), 32'd16);
    chk("long_hold_count", 32'(nhold), 32'd1);
    chk("long_held_level", 32'(bif.o_held[2]), 32'd1);
    b[2] = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      prev_held = bif.o_held[2];
      step(b);
      if (!bif.o_level[2]) begin
        found = 1;
        chk("long_release_together",
            32'({prev_held, bif.o_held[2], bif.o_release_pulse[2]}), 32'b101);
      end
    end
    chk("long_fall_seen", 32'(found), 32'd1);
    repeat (4) step(b);

    // Short press on ch3: no hold activity.
    npress = 0; nrel = 0; nhold = 0; nheld = 0;
    for (int i = 0; i < 25; i++) begin
      b[3] = (i < 10) ? 1'b1 : 1'b0;
      step(b);
      npress += int'(bif.o_press_pulse[3]);
      nrel   += int'(bif.o_release_pulse[3]);
      nhold  += int'(bif.o_hold_pulse[3]);
      nheld  += int'(bif.o_held[3]);
    end
    chk("short_counts", 32'({npress[7:0], nrel[7:0], nhold[7:0], nheld[7:0]}), 32'h01010000);

    // Reset mid-operation: ch2 held, ch0 at debounce count 2.
    b[2] = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(b);
      if (bif.o_held[2]) found = 1;
    end
    chk("reset_pre_held", 32'(found), 32'd1);
    b[0] = 1'b1;
    repeat (4) step(b);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_outputs", 32'(outs()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rise_e = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) chk("reset_first_cycle", 32'(outs()), 32'd0);
      if (bif.o_level[0] && rise_e == 0) rise_e = e;
    end
    chk("reset_relatency", 32'(rise_e), 32'd6);
    b = '0;
    repeat (10) step(b);

    // Randomised phase against the reference model, with occasional async resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int unsigned rng;
      rng = ((cyc / 400) % 2 == 0) ? 32'd40 : 32'd3;
      for (int c = 0; c < NB; c++)
        if ($urandom_range(rng - 1, 0) == 0) b[c] = ~b[c];
      step(b);
      if ($urandom_range(599, 0) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_async_reset", 32'(outs()), 32'd0);
        #1 rst_n = 1'b1;
      end
    end

    b = '0;
    repeat (12) step(b);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
